xge_pkt_loopback: RTL and testbench

//  Store-and-forward packet loopback that sits on the xge_mac client side.
//  - Consumes frames from the MAC receive packet interface (pkt_rx_*).
//  - Drops errored or malformed frames.
//  - Feeds good frames back into the MAC transmit packet interface (pkt_tx_*).
//  - Used as the client-side traffic sink/source in system loopback runs.

---
 rtl/xge_pkt_loopback.sv | 212 +++++++++++++++++++++
 tb/tb_xge_pkt_loopback.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_pkt_loopback.sv
// Store-and-forward client loopback for xge_mac.
// Frames are written speculatively and become readable only once committed.
module xge_pkt_loopback #(
  parameter int DEPTH           = 256,
  parameter int MAX_FRAME_WORDS = 192,
  parameter int CNT_W           = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             enable,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic             pkt_rx_err,
  input  logic [2:0]       pkt_rx_mod,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_tx_full,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic [63:0]      pkt_tx_data,
  output logic [CNT_W-1:0] frames_fwd,
  output logic [CNT_W-1:0] frames_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_MAX = PW'(MAX_FRAME_WORDS);
  localparam logic [PW-1:0] P_GO  = PW'(MAX_FRAME_WORDS + 2);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic {RX_IDLE, RX_READ} rx_st_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_st_e;

  rx_st_e rx_st_q, rx_st_d;
  tx_st_e tx_st_q, tx_st_d;

  logic [67:0]      mem [DEPTH];
  logic [67:0]      ent;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    cm_q, cm_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    free;
  logic [PW-1:0]    base;
  logic [PW-1:0]    len;
  logic             in_frame_q, in_frame_d;
  logic             ovf_q, ovf_d;
  logic             restart, ovf_e, fits;
  logic             we, rx_done, fwd_inc;
  logic [AW-1:0]    waddr;
  logic [1:0]       drop_n;
  logic [CNT_W-1:0] drop_add;
  logic [CNT_W-1:0] fwd_q, fwd_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             rd_en, tx_first;
  logic             val_q, sop_q, eop_q;
  logic [2:0]       mod_q;
  logic [63:0]      data_q;

  assign free = PW'(DEPTH) - (wr_q - rd_q);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rx_st_q <= RX_IDLE;
      tx_st_q <= TX_IDLE;
    end else begin
      rx_st_q <= rx_st_d;
      tx_st_q <= tx_st_d;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    unique case (rx_st_q)
      RX_IDLE:
        if (enable && pkt_rx_avail && free >= P_GO)
          rx_st_d = RX_READ;
      RX_READ:
        if (rx_done)
          rx_st_d = RX_IDLE;
    endcase
  end

  // Stop requesting once the eop word is on the bus.
  always_comb begin
    pkt_rx_ren = (rx_st_q == RX_READ) &&
                 !(pkt_rx_val && pkt_rx_eop);
  end

  always_comb begin
    restart    = in_frame_q && pkt_rx_sop;
    base       = restart ? cm_q : wr_q;
    len        = restart ? '0 : wr_q - cm_q;
    ovf_e      = ovf_q && !restart;
    fits       = len < P_MAX;
    wr_d       = wr_q;
    cm_d       = cm_q;
    in_frame_d = in_frame_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    waddr      = wr_q[AW-1:0];
    fwd_inc    = 1'b0;
    drop_n     = 2'd0;
    rx_done    = 1'b0;
    if (rx_st_q == RX_READ && pkt_rx_val) begin
      if (!in_frame_q && !pkt_rx_sop) begin
        rx_done = pkt_rx_eop;
      end else begin
        drop_n     = {1'b0, restart};
        in_frame_d = 1'b1;
        ovf_d      = ovf_e | ~fits;
        if (fits) begin
          we    = 1'b1;
          waddr = base[AW-1:0];
          wr_d  = base + P_ONE;
        end else begin
          wr_d  = base;
        end
        if (pkt_rx_eop) begin
          rx_done    = 1'b1;
          in_frame_d = 1'b0;
          ovf_d      = 1'b0;
          if (fits && !ovf_e && !pkt_rx_err) begin
            cm_d    = base + P_ONE;
            fwd_inc = 1'b1;
          end else begin
            wr_d   = cm_q;
            drop_n = drop_n + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    drop_add = CNT_W'(drop_n);
    fwd_d    = (fwd_inc && fwd_q != C_MAX) ?
               fwd_q + C_ONE : fwd_q;
    drop_d   = (drop_q > C_MAX - drop_add) ?
               C_MAX : drop_q + drop_add;
  end

  always_ff @(posedge clk_156m25) begin
    if (we)
      mem[waddr] <= {pkt_rx_eop, pkt_rx_mod, pkt_rx_data};
  end

  assign rd_en = !pkt_tx_full && (rd_q != cm_q);
  assign ent   = mem[rd_q[AW-1:0]];
  assign rd_d  = rd_en ? rd_q + P_ONE : rd_q;

  always_comb begin
    tx_st_d = tx_st_q;
    unique case (tx_st_q)
      TX_IDLE:
        if (rd_en && !ent[67])
          tx_st_d = TX_SEND;
      TX_SEND:
        if (rd_en && ent[67])
          tx_st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_first = (tx_st_q == TX_IDLE);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wr_q       <= '0;
      cm_q       <= '0;
      rd_q       <= '0;
      in_frame_q <= 1'b0;
      ovf_q      <= 1'b0;
      fwd_q      <= '0;
      drop_q     <= '0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      mod_q      <= '0;
      data_q     <= '0;
    end else begin
      wr_q       <= wr_d;
      cm_q       <= cm_d;
      rd_q       <= rd_d;
      in_frame_q <= in_frame_d;
      ovf_q      <= ovf_d;
      fwd_q      <= fwd_d;
      drop_q     <= drop_d;
      val_q      <= rd_en;
      sop_q      <= rd_en & tx_first;
      eop_q      <= rd_en & ent[67];
      mod_q      <= rd_en ? ent[66:64] : 3'd0;
      if (rd_en)
        data_q   <= ent[63:0];
    end
  end

  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = sop_q;
  assign pkt_tx_eop  = eop_q;
  assign pkt_tx_mod  = mod_q;
  assign pkt_tx_data = data_q;
  assign frames_fwd  = fwd_q;
  assign frames_drop = drop_q;

endmodule

// File: tb/tb_xge_pkt_loopback.sv
// Randomized bench for xge_pkt_loopback with a frame-level reference model.
// The model parses the rx word stream into expected tx frames and counters.
module tb_xge_pkt_loopback;

  localparam int MAXW = 192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        avail = 1'b0;
  logic        ren;
  logic        rval = 1'b0, rsop = 1'b0, reop = 1'b0, rerr = 1'b0;
  logic [2:0]  rmod = '0;
  logic [63:0] rdata = '0;
  logic        tfull = 1'b0;
  logic        tval, tsop, teop;
  logic [2:0]  tmod;
  logic [63:0] tdata;
  logic [15:0] fwd, drop;

  always #5 clk = ~clk;

  xge_pkt_loopback dut (
    .clk_156m25    (clk),
    .reset_156m25_n(rst_n),
    .enable        (enable),
    .pkt_rx_avail  (avail),
    .pkt_rx_ren    (ren),
    .pkt_rx_val    (rval),
    .pkt_rx_sop    (rsop),
    .pkt_rx_eop    (reop),
    .pkt_rx_err    (rerr),
    .pkt_rx_mod    (rmod),
    .pkt_rx_data   (rdata),
    .pkt_tx_full   (tfull),
    .pkt_tx_val    (tval),
    .pkt_tx_sop    (tsop),
    .pkt_tx_eop    (teop),
    .pkt_tx_mod    (tmod),
    .pkt_tx_data   (tdata),
    .frames_fwd    (fwd),
    .frames_drop   (drop)
  );

  typedef struct packed {
    logic sop; logic eop; logic err;
    logic [2:0] mod; logic [63:0] data;
  } rxw_t;
  typedef struct packed {
    logic sop; logic eop;
    logic [2:0] mod; logic [63:0] data;
  } txw_t;

  rxw_t rxq[$];
  rxw_t mbuf[$];
  txw_t expq[$];

  int errors = 0, checks = 0;
  int cyc = 0, popped = 0, full_mode = 0;
  int m_fwd = 0, m_drop = 0;
  int eop_cyc = 0, sop_cyc = 0;
  bit m_in = 0;
  logic ren_s = 1'b0, full_last = 1'b0;
  logic [63:0] first_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a frame runs sop..eop; a new sop drops the partial.
  task automatic push_word(input bit sop, input bit eop, input bit err,
                           input logic [2:0] mod, input logic [63:0] data);
    rxw_t w;
    w = '{sop: sop, eop: eop, err: err, mod: mod, data: data};
    rxq.push_back(w);
    if (!m_in && !sop) return;
    if (m_in && sop) begin
      m_drop++;
      mbuf.delete();
    end
    m_in = 1;
    mbuf.push_back(w);
    if (eop) begin
      m_in = 0;
      if (!err && mbuf.size() <= MAXW) begin
        m_fwd++;
        foreach (mbuf[k])
          expq.push_back('{sop: (k == 0), eop: mbuf[k].eop,
                           mod: mbuf[k].mod, data: mbuf[k].data});
      end else begin
        m_drop++;
      end
      mbuf.delete();
    end
  endtask

  task automatic push_frame(input int nw, input logic [2:0] mod,
                            input bit err);
    for (int i = 0; i < nw; i++)
      push_word(i == 0, i == nw - 1, err && (i == nw - 1),
                (i == nw - 1) ? mod : 3'd0, {$urandom, $urandom});
  endtask

  task automatic push_bytes(input int nb, input bit err);
    push_frame((nb + 7) / 8, 3'(nb % 8), err);
  endtask

  task automatic drain(input string nm, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rxq.size() == 0 && expq.size() == 0) begin
        done = 1;
        break;
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain: rxq=%0d expq=%0d left, required 0",
               nm, rxq.size(), expq.size());
    end
    chk({nm, "_fwd_model"}, 64'(fwd), 64'(m_fwd));
    chk({nm, "_drop_model"}, 64'(drop), 64'(m_drop));
  endtask

  task automatic wait_pop(input string nm, input int target,
                          input int budget);
    int i;
    for (i = 0; i < budget && popped < target; i++)
      @(negedge clk);
    checks++;
    if (popped < target) begin
      errors++;
      $display("FAIL %s wait: popped=%0d required %0d", nm, popped, target);
    end
  endtask

  // MAC model: data follows ren by one cycle.
  always begin
    rxw_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      rval = 0; rsop = 0; reop = 0; rerr = 0;
      rmod = '0; rdata = '0; avail = 0; tfull = 0;
    end else begin
      case (full_mode)
        1: tfull = ($urandom % 4) == 0;
        2: tfull = ~tfull;
        3: tfull = 1'b1;
        default: tfull = 1'b0;
      endcase
      if (ren_s && rxq.size() > 0) begin
        w = rxq.pop_front();
        rval = 1; rsop = w.sop; reop = w.eop; rerr = w.err;
        rmod = w.mod; rdata = w.data;
        popped++;
      end else begin
        rval = 0; rsop = 0; reop = 0; rerr = 0;
        rmod = '0; rdata = '0;
      end
      avail = rxq.size() > 0;
    end
  end

  always @(negedge clk) begin
    txw_t e;
    ren_s = ren;
    if (!rst_n) begin
      full_last = 1'b0;
    end else begin
      if (full_last)
        chk("full_gap_val", 64'(tval), 64'd0);
      full_last = tfull;
      if (rval && reop)
        eop_cyc = cyc;
      if (tval) begin
        if (tsop) begin
          sop_cyc = cyc;
          first_data = tdata;
        end
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: data=%0h with empty model", tdata);
        end else begin
          e = expq.pop_front();
          chk("tx_sop", 64'(tsop), 64'(e.sop));
          chk("tx_eop", 64'(teop), 64'(e.eop));
          chk("tx_mod", 64'(tmod), 64'(e.mod));
          chk("tx_data", tdata, e.data);
        end
      end
    end
  end

  initial begin
    int p0, r;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ren", 64'(ren), 0);
    chk("rst_val", 64'(tval), 0);
    chk("rst_data", tdata, 0);
    chk("rst_fwd", 64'(fwd), 0);
    chk("rst_drop", 64'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;

    // 64B frame, known data, latency pin
    for (int i = 0; i < 8; i++)
      push_word(i == 0, i == 7, 0, 3'd0, 64'h1000_0000_0000_0000 + 64'(i));
    drain("s1", 500);
    chk("s1_fwd", 64'(fwd), 1);
    chk("s1_drop", 64'(drop), 0);
    chk("s1_latency", 64'(sop_cyc - eop_cyc), 2);
    chk("s1_first_data", first_data, 64'h1000_0000_0000_0000);

    push_bytes(64, 1);
    push_bytes(60, 0);
    drain("s2", 500);
    chk("s2_fwd", 64'(fwd), 2);
    chk("s2_drop", 64'(drop), 1);

    full_mode = 2;
    push_bytes(1518, 0);
    drain("s3", 2000);
    chk("s3_fwd", 64'(fwd), 3);
    full_mode = 0;

    // Buffer fills with one 190-word frame while tx is blocked
    full_mode = 3;
    p0 = popped;
    repeat (3) push_bytes(1518, 0);
    repeat (600) @(negedge clk);
    chk("s4_rx_words_while_full", 64'(popped - p0), 190);
    full_mode = 0;
    drain("s4", 3000);
    chk("s4_fwd", 64'(fwd), 6);
    chk("s4_drop", 64'(drop), 1);

    push_word(1, 0, 0, 3'd0, 64'hAAAA);
    push_word(0, 0, 0, 3'd0, 64'hBBBB);
    push_word(0, 0, 0, 3'd0, 64'hCCCC);
    push_bytes(64, 0);
    drain("s5", 500);
    chk("s5_fwd", 64'(fwd), 7);
    chk("s5_drop", 64'(drop), 2);

    push_frame(MAXW, 3'd0, 0);
    push_frame(MAXW + 1, 3'd0, 0);
    push_frame(1, 3'd5, 0);
    push_word(0, 0, 0, 3'd0, 64'h1);
    push_word(0, 1, 0, 3'd0, 64'h2);
    push_bytes(64, 0);
    drain("bound", 3000);
    chk("bound_fwd", 64'(fwd), 10);
    chk("bound_drop", 64'(drop), 3);

    enable = 1'b0;
    p0 = popped;
    push_bytes(64, 0);
    repeat (40) @(negedge clk);
    chk("disabled_no_read", 64'(popped - p0), 0);
    chk("disabled_no_tx", 64'(expq.size()), 8);
    enable = 1'b1;
    drain("reenable", 500);

    p0 = popped;
    push_frame(190, 3'd3, 0);
    wait_pop("en_mid", p0 + 5, 200);
    enable = 1'b0;
    drain("en_mid", 1000);
    chk("en_mid_fwd", 64'(fwd), 12);
    enable = 1'b1;

    full_mode = 1;
    for (int f = 0; f < 40; f++) begin
      r = $urandom % 16;
      if (r == 0)
        push_word(0, $urandom % 2, 0, 3'd0, {$urandom, $urandom});
      else if (r == 1)
        push_frame(1 + $urandom % 6, 3'd0, 0);
      else if (r == 2) begin
        push_word(1, 0, 0, 3'd0, {$urandom, $urandom});
        repeat ($urandom % 5)
          push_word(0, 0, 0, 3'd0, {$urandom, $urandom});
      end else
        push_frame(1 + $urandom % 200, 3'($urandom),
                   ($urandom % 8) == 0);
    end
    push_bytes(64, 0);
    drain("rand", 30000);
    full_mode = 0;

    // Reset in the middle of a 16-word frame
    p0 = popped;
    push_frame(16, 3'd0, 0);
    wait_pop("rst_mid", p0 + 4, 200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ren", 64'(ren), 0);
    chk("rst_mid_val", 64'(tval), 0);
    chk("rst_mid_sop", 64'(tsop), 0);
    chk("rst_mid_eop", 64'(teop), 0);
    chk("rst_mid_mod", 64'(tmod), 0);
    chk("rst_mid_data", tdata, 0);
    chk("rst_mid_fwd", 64'(fwd), 0);
    chk("rst_mid_drop", 64'(drop), 0);
    rxq.delete();
    expq.delete();
    mbuf.delete();
    m_in = 0;
    m_fwd = 0;
    m_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_bytes(64, 0);
    drain("post_rst", 500);
    chk("post_rst_fwd", 64'(fwd), 1);
    chk("post_rst_drop", 64'(drop), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
